// File: rtl/dac_sd_if.sv
// dac_sd_if: start/code request and bitstream/status response of the sigma-delta DAC
interface dac_sd_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] digital_input;
  logic             analog_output;
  logic             busy;
  logic             conversion_done;
  modport master(output start, digital_input, input analog_output, busy, conversion_done);
  modport slave(input start, digital_input, output analog_output, busy, conversion_done);
endinterface

// File: rtl/dac_sd.sv
// dac_sd: first-order sigma-delta DAC emitting exactly `code` ones per 2^WIDTH-bit frame
module dac_sd #(parameter int WIDTH = 8) (
  input logic   clk,
  input logic   rst,
  dac_sd_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] code, acc, cnt, code_n, acc_n, cnt_n;
  logic [WIDTH:0]   sum;
  logic             out_n, busy_n, done_n;
  assign sum = {1'b0, acc} + {1'b0, code};
  always_comb begin
    state_n = state;
    code_n  = code;
    acc_n   = acc;
    cnt_n   = cnt;
    out_n   = 1'b0;
    busy_n  = bus.busy;
    done_n  = 1'b0;
    if (bus.start) begin
      code_n  = bus.digital_input;
      acc_n   = '0;
      cnt_n   = '0;
      state_n = CONVERT;
      busy_n  = 1'b1;
    end else begin
      unique case (state)
        CONVERT: begin
          acc_n   = sum[WIDTH-1:0];
          out_n   = sum[WIDTH];
          cnt_n   = cnt + 1'b1;
          state_n = &cnt ? DONE : CONVERT;
          busy_n  = 1'b1;
        end
        DONE: begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
        default: busy_n = 1'b0;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      code                <= '0;
      acc                 <= '0;
      cnt                 <= '0;
      bus.analog_output   <= 1'b0;
      bus.busy            <= 1'b0;
      bus.conversion_done <= 1'b0;
    end else begin
      state               <= state_n;
      code                <= code_n;
      acc                 <= acc_n;
      cnt                 <= cnt_n;
      bus.analog_output   <= out_n;
      bus.busy            <= busy_n;
      bus.conversion_done <= done_n;
    end
  end
endmodule

// File: tb/tb_dac_sd.sv
// tb_dac_sd: randomized frame checks against an arithmetic ones-density model
module tb_dac_sd;
  localparam int WIDTH = 8;
  localparam int FRAME = 1 << WIDTH;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  dac_sd_if #(.WIDTH(WIDTH)) bus ();
  dac_sd #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int exp_bit(input int c, input int k);
    return ((k * c) / FRAME) - (((k - 1) * c) / FRAME);
  endfunction
  task automatic begin_frame(input int c, input int nbits, output int ones);
    bus.start = 1'b1;
    bus.digital_input = WIDTH'(c);
    step();
    bus.start = 1'b0;
    check("start_busy", int'(bus.busy), 1);
    check("start_out", int'(bus.analog_output), 0);
    ones = 0;
    for (int k = 1; k <= nbits; k++) begin
      bus.digital_input = WIDTH'($urandom);
      step();
      check("bit", int'(bus.analog_output), exp_bit(c, k));
      check("busy_frame", int'(bus.busy), 1);
      check("no_early_done", int'(bus.conversion_done), 0);
      ones += int'(bus.analog_output);
    end
  endtask
  task automatic frame(input int c);
    int ones;
    begin_frame(c, FRAME, ones);
    check("ones_count", ones, c);
    step();
    check("done_pulse", int'(bus.conversion_done), 1);
    check("done_busy", int'(bus.busy), 0);
    check("done_out", int'(bus.analog_output), 0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("idle_done", int'(bus.conversion_done), 0);
      check("idle_busy", int'(bus.busy), 0);
      check("idle_out", int'(bus.analog_output), 0);
    end
  endtask
  initial begin
    int ones;
    bus.start = 1'b1;
    bus.digital_input = 8'd200;
    rst = 1'b1;
    step();
    step();
    check("rst_out", int'(bus.analog_output), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.conversion_done), 0);
    rst = 1'b0;
    bus.start = 1'b0;
    idle(3);
    frame(128);
    idle(2);
    frame(0);
    idle(1);
    frame(255);
    idle(1);
    frame(1);
    idle(1);
    for (int c = 0; c < FRAME; c++) frame(c);
    idle(2);
    begin_frame(200, 100, ones);
    frame(50);
    idle(2);
    begin_frame(77, 30, ones);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_out", int'(bus.analog_output), 0);
    check("mrst_busy", int'(bus.busy), 0);
    check("mrst_done", int'(bus.conversion_done), 0);
    idle(5);
    frame(77);
    idle(1);
    for (int i = 0; i < 12; i++) begin
      frame(int'($urandom_range(0, FRAME - 1)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 4)));
    end
    idle(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
